// File: rtl/data_mem_responder_if.sv
// Load/store port between the pipeline (master) and the data-memory
// responder (slave). The core drives the request fields; the responder
// answers with ready/done/err and the load result.
interface data_mem_responder_if #(
   parameter int ADDR_W = 9
);
   logic              wr;
   logic              rd;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wr_data;
   logic [1:0]        size;
   logic              unsigned_ld;
   logic              ready;
   logic              done;
   logic              err;
   logic [31:0]       rd_data;

   modport master (
      output wr, rd, addr, wr_data, size, unsigned_ld,
      input  ready, done, err, rd_data
   );

   modport slave (
      input  wr, rd, addr, wr_data, size, unsigned_ld,
      output ready, done, err, rd_data
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline load/store port.
// Byte-addressed storage (2**ADDR_W bytes as four byte lanes of 32-bit
// words), byte/half/word accesses with sign/zero-extended loads and
// alignment checks, answered after a fixed LATENCY through ready/done.
// Optional macro DATA_MEM_TRACE_EN: prints a simulation trace line for
// every committed access and for every rejected request.
module data_mem_responder #(
   parameter int ADDR_W  = 9,
   parameter int LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   data_mem_responder_if.slave   bus
);
   localparam int         WORDS    = 2 ** (ADDR_W - 2);
   localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_cnt;
   logic              r_wr;
   logic              r_rd;
   logic              r_unsigned;
   logic              r_err;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wr_data;
   logic [1:0]        r_size;
   logic [31:0]       r_rd_data;

   logic              w_accept;
   logic              w_req_err;
   logic              w_to_done;
   logic              w_store;
   logic              w_load;
   // Effective request: live inputs while idle (LATENCY=1 / error commit on
   // the acceptance edge), captured copy afterwards.
   logic              w_e_wr;
   logic              w_e_rd;
   logic              w_e_uns;
   logic              w_e_err;
   logic [ADDR_W-1:0] w_e_addr;
   logic [31:0]       w_e_data;
   logic [1:0]        w_e_size;

   logic [ADDR_W-3:0] w_word_idx;
   logic [3:0]        w_be;
   logic [31:0]       w_lane_data;
   logic [31:0]       w_rd_word;
   logic [31:0]       w_shifted;
   logic [31:0]       w_load_val;

   assign w_accept  = (r_state == S_IDLE) && (bus.wr || bus.rd);
   assign w_req_err = (bus.size == 2'b11)
                    || ((bus.size == 2'b01) && bus.addr[0])
                    || ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00))
                    || (bus.wr && bus.rd);

   // Select which copy of the request the commit logic works on
   always_comb begin
      if (r_state == S_IDLE) begin
         w_e_wr   = bus.wr;
         w_e_rd   = bus.rd;
         w_e_uns  = bus.unsigned_ld;
         w_e_err  = w_req_err;
         w_e_addr = bus.addr;
         w_e_data = bus.wr_data;
         w_e_size = bus.size;
      end else begin
         w_e_wr   = r_wr;
         w_e_rd   = r_rd;
         w_e_uns  = r_unsigned;
         w_e_err  = r_err;
         w_e_addr = r_addr;
         w_e_data = r_wr_data;
         w_e_size = r_size;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_next = ((LATENCY == 1) || w_req_err) ? S_DONE : S_BUSY;
         S_BUSY: if (r_cnt == 4'd0) w_state_next = S_DONE;
         S_DONE: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      bus.ready   = (r_state == S_IDLE);
      bus.done    = (r_state == S_DONE);
      bus.err     = (r_state == S_DONE) && r_err;
      bus.rd_data = r_rd_data;
   end

   // Commit happens on the edge that enters DONE; reset suppresses it so an
   // in-flight store never reaches memory.
   assign w_to_done = (w_state_next == S_DONE) && (r_state != S_DONE);
   assign w_store   = reset && w_to_done && !w_e_err && w_e_wr;
   assign w_load    = reset && w_to_done && !w_e_err && w_e_rd;

   // Request capture and latency countdown
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= 4'd0;
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wr_data  <= 32'd0;
         r_size     <= 2'b00;
      end else if (w_accept) begin
         r_cnt      <= CNT_INIT;
         r_wr       <= bus.wr;
         r_rd       <= bus.rd;
         r_unsigned <= bus.unsigned_ld;
         r_err      <= w_req_err;
         r_addr     <= bus.addr;
         r_wr_data  <= bus.wr_data;
         r_size     <= bus.size;
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      w_be        = 4'b1111;
      w_lane_data = w_e_data;
      case (w_e_size)
         2'b00: begin
            w_be        = 4'b0001 << w_e_addr[1:0];
            w_lane_data = {4{w_e_data[7:0]}};
         end
         2'b01: begin
            w_be        = w_e_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{w_e_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_word_idx = w_e_addr[ADDR_W-1:2];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] r_mem [WORDS];
         // One byte lane of storage; contents survive reset
         always_ff @(posedge clk) begin
            if (w_store && w_be[gi]) r_mem[w_word_idx] <= w_lane_data[gi*8 +: 8];
         end
         assign w_rd_word[gi*8 +: 8] = r_mem[w_word_idx];
      end
   endgenerate

   // Extract and extend the addressed load data
   always_comb begin
      w_shifted  = w_rd_word >> {w_e_addr[1:0], 3'b000};
      w_load_val = w_rd_word;
      case (w_e_size)
         2'b00: w_load_val = w_e_uns ? {24'd0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01: w_load_val = w_e_uns ? {16'd0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
         default: ;
      endcase
   end

   // Load result register, updated only by successful loads
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      r_rd_data <= 32'd0;
      else if (w_load) r_rd_data <= w_load_val;
   end

`ifdef DATA_MEM_TRACE_EN
   logic [31:0] w_trace_store;
   assign w_trace_store = (w_e_size == 2'b00) ? {24'd0, w_e_data[7:0]} :
                          (w_e_size == 2'b01) ? {16'd0, w_e_data[15:0]} : w_e_data;
   // Simulation trace of every commit or rejection
   always @(posedge clk) begin
      if (reset && w_to_done) begin
         if (w_e_err)
            $display("%0t Memory error addr=%0d", $time, w_e_addr);
         else if (w_e_wr)
            $display("%0t store addr=%0d data=%08h/%0d", $time, w_e_addr, w_trace_store, w_trace_store);
         else
            $display("%0t load addr=%0d data=%08h/%0d", $time, w_e_addr, w_load_val, w_load_val);
      end
   end
`else
   // Trace disabled: no display logic is compiled.
`endif
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the riscv pipeline's load/store port. It answers the core's wr/rd/addr/wr_data requests and returns rd_data.
- Byte-addressed storage with RISC-V access sizes, sign/zero extension on loads, and misalignment checks.
- Fixed, parameterised access latency with a ready/done handshake, so the core's stall logic can be exercised.

Parameters:
- ADDR_W, 9, byte-address width; storage is 2**ADDR_W bytes organised as 32-bit words.
- LATENCY, 2, cycles from request acceptance to response (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- wr  input  1  store request.
- rd  input  1  load request.
- addr  input  ADDR_W  byte address.
- wr_data  input  32  store data; low bytes are used for sub-word stores.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- unsigned_ld  input  1  1 = zero-extend load, 0 = sign-extend.
- ready  output  1  responder idle; a request is accepted this cycle.
- done  output  1  one-cycle response strobe.
- err  output  1  valid with done; request was rejected.
- rd_data  output  32  load result.

Behaviour:
- Reset (reset=0, async): state IDLE, ready=1, done=0, err=0, rd_data=0.
  - The latency counter and captured request are cleared.
  - Memory contents are not reset.
  - An in-flight store is discarded and memory is left unchanged.
- FSM states:
  - IDLE: ready=1. On a rising edge with wr|rd=1, the request is accepted: addr, wr_data, size, unsigned_ld and the op are captured. Next state is DONE if LATENCY=1 or the request is erroneous, else BUSY with cnt=LATENCY-2.
  - BUSY: ready=0. cnt decrements each edge; at cnt=0 the next state is DONE.
  - DONE: ready=0, done=1 for exactly one cycle, then IDLE.
- Timing:
  - Acceptance edge at cycle 0; done=1 during cycle LATENCY (error: cycle 1). ready returns to 1 the cycle after done.
  - Throughput is one access per LATENCY+1 cycles.
  - Inputs are sampled only at acceptance; later changes are ignored.
- Commit: the store write and the load-data latch happen on the edge entering DONE.
  - rd_data updates only on a successful load and holds its value otherwise.
- Error cases: err=1 with done, no memory effect, rd_data unchanged.
  - size=11.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - wr and rd both 1.
- Stores by size:
  - Byte: writes wr_data[7:0] to byte addr.
  - Half: writes wr_data[15:0] to bytes addr and addr+1, little-endian.
  - Word: writes all four bytes.
  - Untouched bytes are preserved.
- Loads: extract the addressed byte/half/word (little-endian), then extend to 32 bits per unsigned_ld. unsigned_ld is ignored for word loads.
- Address range is fully covered; there is no out-of-range case. Alignment is the only address check.
- err is 0 whenever done=0.

Optional Feature:
- DATA_MEM_TRACE_EN defined: on every successful commit, simulation $display prints $time, op (store/load), addr in decimal, and the data in both hex and decimal.
  - A rejected request prints one line "Memory error" with addr.
- Not defined: no display code is compiled and behaviour is otherwise identical.

Test Plan:
- Word round-trip, LATENCY=2: store word 0xDEADBEEF at addr 0, then load word at addr 0 -> rd_data=0xDEADBEEF. done=1 exactly 2 cycles after each acceptance edge, ready=0 during cycles 1..2.
- Byte access: store word 0x11223344 at addr 4, then store byte 0x80 at addr 5.
  - Load byte addr 5 -> 0xFFFFFF80.
  - Load byte unsigned addr 5 -> 0x00000080.
  - Load word addr 4 -> 0x11228044.
- Half access: store half 0xBEEF at addr 6.
  - Load half addr 6 -> 0xFFFFBEEF.
  - Load half unsigned -> 0x0000BEEF.
  - Load word addr 4 -> 0xBEEF8044.
- Errors: load half at addr 3, store word at addr 2, size=11, and wr=rd=1 -> each gives done=1, err=1 one cycle after acceptance. rd_data and memory are unchanged (confirm by load word addr 0 -> 0xDEADBEEF).
- Reset mid-operation: store word 0xCAFEF00D at addr 0, assert reset during BUSY.
  - Immediately after reset: ready=1, done=0, err=0, rd_data=0.
  - A subsequent load word at addr 0 returns 0xDEADBEEF.
- Build with DATA_MEM_TRACE_EN and LATENCY=1: store 5 at addr 8 -> one trace line with addr 8 and value 00000005/5. done appears the cycle after acceptance.
